csr_uart_char: RTL and testbench
================================

Name: csr_uart_char

Overview:
- Memory-less UART peripheral mapped onto a single CPU CSR address (default 0x7C0).
- Transmits and receives 8N1 characters.
- Sits on the shared CSR bus beside the counter and LED CSRs; its rdata/valid are OR-combined with the other CSR slaves and returned to the pipeline.

Parameters:
- BASE_ADDR, 12'h7C0, CSR address this block answers to.
- CLOCK_RATE, 50_000_000, clk frequency in Hz.
- BAUD_RATE, 115200, serial bit rate. DIV = CLOCK_RATE/BAUD_RATE, integer-truncated (434 at defaults).

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- read  in  1  CSR read strobe; consumes the received byte when addr matches.
- modify  in  3  CSR write mode. [1:0]: 00 none, 01 write, 10 set, 11 clear. Bit 2 is ignored.
- wdata  in  32  CSR write data; [7:0] is the character to send.
- addr  in  12  CSR address.
- rdata  out  32  registered read data; zero when not addressed.
- valid  out  1  registered "address claimed" flag.
- rx  in  1  serial input, asynchronous, idle high.
- tx  out  1  serial output, idle high.
- AVOID_WARNING  out  1  = |wdata[31:8] | modify[2]; has no function.

Behaviour:
- Reset (asynchronous, rstn=0) forces:
  - tx=1, valid=0, rdata=0.
  - rx_full=0, tx_busy=0.
  - Both state machines to IDLE.
- CSR access (registered, one-cycle latency):
  - Each cycle, valid<=0 and rdata<=0 by default.
  - If addr==BASE_ADDR: valid<=1 and rdata<=STATUS, with STATUS computed from pre-edge state.
  - STATUS = {~rx_full, tx_busy, 22'b0, rx_full ? rx_byte : 8'h00}.
  - So "no character" reads as negative (bit 31 = 1).
- Consume:
  - addr match with read=1 clears rx_full at the same edge.
  - If a new byte completes in that same cycle, the new byte is stored and rx_full stays 1.
- Transmit start:
  - Triggered by addr match, modify[1:0]==01 and tx_busy==0.
  - Latch wdata[7:0], set tx_busy, enter the TX frame on the next cycle.
  - Write while tx_busy=1 is silently dropped.
  - modify 10/11 are ignored.
- TX FSM states: IDLE, START, DATA(8 bits, LSB first), STOP.
  - Each state holds tx for exactly DIV cycles: START drives 0, DATA drives bit i, STOP drives 1.
  - Full frame = 10*DIV cycles.
  - tx_busy clears at the end of STOP; a new write is accepted the following cycle.
- RX path:
  - Two-flop synchronizer on rx before any logic.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: on synchronized falling edge (1→0), go to START and load counter with DIV/2.
  - START: at mid-bit, if the line is still 0 go to DATA; else return to IDLE (glitch reject).
  - DATA: sample every DIV cycles, 8 bits, LSB first, shifted into a register.
  - STOP: sample after DIV cycles.
    - Sample = 1: rx_byte <= shifted value, rx_full <= 1. An unread byte is overwritten.
    - Sample = 0 (framing error): discard the byte, rx_full unchanged.
  - Return to IDLE immediately after STOP; a back-to-back start bit is detected.
- TX and RX are fully independent; full duplex is supported.
- Counters are wide enough for DIV (ceil(log2(DIV+1)) bits, minimum 1).
- Reset asserted mid-frame aborts both FSMs at once; tx returns high and any partial byte is lost.

Test Plan:
- Reset, then a read at 0x7C0 → one cycle later valid=1, rdata=0x8000_0000. Read at 0x7C1 → valid=0, rdata=0.
- Write 0x55 with modify=01 (DIV=434) → tx shows start bit low for 434 cycles, bits 1,0,1,0,1,0,1,0, then stop high. Status bit 30 is 1 during the frame and 0 after 4340 cycles.
- Second write (0x41) issued 100 cycles into a frame → ignored; only 0x55 appears on tx. A write after completion sends 0x41.
- Drive frame 0xA3 on rx at 115200 baud → status reads 0x0000_00A3. A read clears it, and the next read returns 0x8000_0000.
- Drive a 0xC3 frame with stop bit 0 → rx_full stays 0. Drive a 100-cycle low glitch → no byte received.
- Reset pulse mid-TX frame → tx=1 immediately and tx_busy=0. A new write afterwards produces a clean frame.

Source files
------------

// File: rtl/csr_uart_char.sv
// 8N1 UART peripheral behind a single CSR address: a write starts a TX frame, a read returns and consumes the RX byte.
// CSR read data and valid are registered (one-cycle latency); a TX frame lasts 10*DIV cycles.
// No backpressure: writes while busy are dropped, and an unread RX byte is overwritten by the next good frame.
module csr_uart_char #(
  parameter logic [11:0] BASE_ADDR  = 12'h7C0,
  parameter int          CLOCK_RATE = 50_000_000,
  parameter int          BAUD_RATE  = 115200
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        read,
  input  logic [2:0]  modify,
  input  logic [31:0] wdata,
  input  logic [11:0] addr,
  output logic [31:0] rdata,
  output logic        valid,
  input  logic        rx,
  output logic        tx,
  output logic        AVOID_WARNING
);

  localparam int DIV = CLOCK_RATE / BAUD_RATE;
  localparam int CW  = (DIV < 1) ? 1 : $clog2(DIV + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_e;

  // Transmit path state
  state_e          tx_state_q, tx_state_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            tx_q, tx_d;
  logic            tx_busy_q, tx_busy_d;

  // Receive path state
  logic            rx_sync1_q, rx_sync2_q, rx_prev_q;
  state_e          rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic            rx_full_q, rx_full_d;
  logic            rx_done;

  // CSR response
  logic [31:0]     rdata_q, rdata_d;
  logic            valid_q, valid_d;

  logic            hit;
  logic            tx_start;
  logic            rx_fall;

  assign hit      = (addr == BASE_ADDR);
  assign tx_start = hit && (modify[1:0] == 2'b01) && !tx_busy_q;
  assign rx_fall  = rx_prev_q && !rx_sync2_q;

  // TX frame sequencer: START, 8 data bits LSB first, STOP, each held DIV cycles
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    tx_busy_d  = tx_busy_q;
    case (tx_state_q)
      ST_IDLE: begin
        if (tx_start) begin
          tx_state_d = ST_START;
          tx_cnt_d   = CNT_FULL;
          tx_bit_d   = 3'd0;
          tx_shift_d = wdata[7:0];
          tx_d       = 1'b0;
          tx_busy_d  = 1'b1;
        end
      end
      ST_START: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = ST_DATA;
          tx_cnt_d   = CNT_FULL;
          tx_bit_d   = 3'd0;
          tx_d       = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q - CW'(1);
        end
      end
      ST_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = CNT_FULL;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = ST_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_d       = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q - CW'(1);
        end
      end
      ST_STOP: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = ST_IDLE;
          tx_busy_d  = 1'b0;
          tx_d       = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q - CW'(1);
        end
      end
      default: begin
        tx_state_d = ST_IDLE;
        tx_busy_d  = 1'b0;
        tx_d       = 1'b1;
      end
    endcase
  end

  // RX frame sequencer: mid-bit sampling from the start edge, glitch reject, stop-bit framing check
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_byte_d  = rx_byte_q;
    rx_done    = 1'b0;
    case (rx_state_q)
      ST_IDLE: begin
        if (rx_fall) begin
          rx_state_d = ST_START;
          rx_cnt_d   = CNT_HALF;
        end
      end
      ST_START: begin
        if (rx_cnt_q == '0) begin
          if (!rx_sync2_q) begin
            rx_state_d = ST_DATA;
            rx_cnt_d   = CNT_FULL;
            rx_bit_d   = 3'd0;
          end else begin
            rx_state_d = ST_IDLE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CW'(1);
        end
      end
      ST_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
          rx_cnt_d   = CNT_FULL;
          if (rx_bit_q == 3'd7) begin
            rx_state_d = ST_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CW'(1);
        end
      end
      ST_STOP: begin
        if (rx_cnt_q == '0) begin
          rx_state_d = ST_IDLE;
          if (rx_sync2_q) begin
            rx_byte_d = rx_shift_q;
            rx_done   = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CW'(1);
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
    // A byte completing in the same cycle as a consuming read wins
    rx_full_d = rx_full_q;
    if (hit && read) rx_full_d = 1'b0;
    if (rx_done)     rx_full_d = 1'b1;
  end

  // CSR response built from pre-edge state; "no character" reads negative
  always_comb begin
    valid_d = hit;
    rdata_d = 32'h0;
    if (hit) begin
      rdata_d = {~rx_full_q, tx_busy_q, 22'b0, rx_full_q ? rx_byte_q : 8'h00};
    end
  end

  // State registers; reset aborts both frames and parks the lines idle-high
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_byte_q  <= 8'h00;
      rx_full_q  <= 1'b0;
      rdata_q    <= 32'h0;
      valid_q    <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      tx_busy_q  <= tx_busy_d;
      rx_sync1_q <= rx;
      rx_sync2_q <= rx_sync1_q;
      rx_prev_q  <= rx_sync2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_byte_q  <= rx_byte_d;
      rx_full_q  <= rx_full_d;
      rdata_q    <= rdata_d;
      valid_q    <= valid_d;
    end
  end

  assign rdata         = rdata_q;
  assign valid         = valid_q;
  assign tx            = tx_q;
  assign AVOID_WARNING = |wdata[31:8] | modify[2];

endmodule

// File: tb/tb_csr_uart_char.sv
// Bench for csr_uart_char at default parameters (DIV = 434).
// Drives CSR accesses and serial frames; expectations come from a byte-level model of the UART.
// All stimulus changes on the falling clock edge; outputs are sampled on the falling edge.
module tb_csr_uart_char;

  localparam int DIV = 50_000_000 / 115200;

  logic        clk = 1'b0;
  logic        rstn;
  logic        read;
  logic [2:0]  modify;
  logic [31:0] wdata;
  logic [11:0] addr;
  logic [31:0] rdata;
  logic        valid;
  logic        rx;
  logic        tx;
  logic        avoid_w;

  int checks = 0;
  int errors = 0;

  // Byte-level model of the receive holding register
  logic       model_full;
  logic [7:0] model_byte;

  always #5 clk = ~clk;

  csr_uart_char dut (
    .clk          (clk),
    .rstn         (rstn),
    .read         (read),
    .modify       (modify),
    .wdata        (wdata),
    .addr         (addr),
    .rdata        (rdata),
    .valid        (valid),
    .rx           (rx),
    .tx           (tx),
    .AVOID_WARNING(avoid_w)
  );

  function automatic logic [31:0] exp_status(input logic busy);
    return {~model_full, busy, 22'b0, model_full ? model_byte : 8'h00};
  endfunction

  task automatic csr_access(input logic [11:0] a, input logic rd, input logic [2:0] md,
                            input logic [31:0] wd, output logic [31:0] rdat, output logic vld);
    addr = a; read = rd; modify = md; wdata = wd;
    @(posedge clk);
    @(negedge clk);
    rdat = rdata; vld = valid;
    addr = 12'h000; read = 1'b0; modify = 3'b000; wdata = 32'h0;
  endtask

  // Watches tx for one frame, sampling each bit at its middle
  task automatic capture_tx(output logic [7:0] b, output int low_run, output logic start_ok,
                            output logic stop_ok, output logic found);
    int   k;
    logic run;
    b = 8'h00; low_run = 0; start_ok = 1'b0; stop_ok = 1'b0; found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) return;
    k = 1; low_run = 1; run = 1'b1;
    while (k < 9 * DIV + DIV / 2) begin
      @(negedge clk);
      k++;
      if (run && tx === 1'b0) low_run++;
      else run = 1'b0;
      if (k == DIV / 2) start_ok = (tx === 1'b0);
      for (int i = 0; i < 8; i++) if (k == (i + 1) * DIV + DIV / 2) b[i] = tx;
      if (k == 9 * DIV + DIV / 2) stop_ok = (tx === 1'b1);
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = stop_bit;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] rd_v;
    logic        vl;
    rstn = 1'b0; read = 1'b0; modify = 3'b000; wdata = 32'h0; addr = 12'h000; rx = 1'b1;
    model_full = 1'b0; model_byte = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b expected 1", tx); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", valid); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h expected 00000000", rdata); end
    rstn = 1'b1;
    @(negedge clk);
    csr_access(12'h7C0, 1'b1, 3'b000, 32'h0, rd_v, vl);
    checks++; if (vl !== 1'b1) begin errors++; $display("FAIL idle_read_valid got %b expected 1", vl); end
    checks++; if (rd_v !== 32'h8000_0000) begin errors++; $display("FAIL idle_read_rdata got %h expected 80000000", rd_v); end
    csr_access(12'h7C1, 1'b1, 3'b000, 32'h0, rd_v, vl);
    checks++; if (vl !== 1'b0) begin errors++; $display("FAIL other_addr_valid got %b expected 0", vl); end
    checks++; if (rd_v !== 32'h0) begin errors++; $display("FAIL other_addr_rdata got %h expected 00000000", rd_v); end
    wdata = 32'h0000_0100;
    #1;
    checks++; if (avoid_w !== 1'b1) begin errors++; $display("FAIL avoid_warning got %b expected 1", avoid_w); end
    wdata = 32'h0;
    @(negedge clk);
  endtask

  task automatic test_tx_frame();
    logic [7:0]  b;
    int          low_run;
    logic        s_ok, p_ok, fnd, saw_low;
    logic [31:0] r0, r1, r2, r3;
    logic        v0, v1, v2, v3;
    fork
      capture_tx(b, low_run, s_ok, p_ok, fnd);
      begin
        csr_access(12'h7C0, 1'b0, 3'b001, 32'h0000_0055, r0, v0);
        repeat (99) @(negedge clk);
        csr_access(12'h7C0, 1'b0, 3'b001, 32'h0000_0041, r1, v1);
        repeat (10 * DIV - 101) @(negedge clk);
        csr_access(12'h7C0, 1'b0, 3'b000, 32'h0, r2, v2);
        csr_access(12'h7C0, 1'b0, 3'b000, 32'h0, r3, v3);
      end
    join
    checks++; if (v0 !== 1'b1 || r0 !== exp_status(1'b0)) begin errors++; $display("FAIL write_resp got %b/%h expected 1/%h", v0, r0, exp_status(1'b0)); end
    checks++; if (fnd !== 1'b1) begin errors++; $display("FAIL tx_start_seen got %b expected 1", fnd); end
    checks++; if (low_run != DIV) begin errors++; $display("FAIL tx_start_len got %0d expected %0d", low_run, DIV); end
    checks++; if (b !== 8'h55) begin errors++; $display("FAIL tx_byte_55 got %h expected 55", b); end
    checks++; if (p_ok !== 1'b1 || s_ok !== 1'b1) begin errors++; $display("FAIL tx_framing_55 got start %b stop %b expected 1 1", s_ok, p_ok); end
    checks++; if (r1 !== exp_status(1'b1)) begin errors++; $display("FAIL busy_mid_frame got %h expected %h", r1, exp_status(1'b1)); end
    checks++; if (r2 !== exp_status(1'b1)) begin errors++; $display("FAIL busy_last_cycle got %h expected %h", r2, exp_status(1'b1)); end
    checks++; if (r3 !== exp_status(1'b0)) begin errors++; $display("FAIL busy_cleared got %h expected %h", r3, exp_status(1'b0)); end
    saw_low = 1'b0;
    repeat (2 * DIV) begin
      @(negedge clk);
      if (tx !== 1'b1) saw_low = 1'b1;
    end
    checks++; if (saw_low !== 1'b0) begin errors++; $display("FAIL dropped_write_idle got low %b expected 0", saw_low); end
  endtask

  task automatic test_tx_after_drop();
    logic [7:0]  b;
    int          low_run;
    logic        s_ok, p_ok, fnd, v;
    logic [31:0] r;
    fork
      capture_tx(b, low_run, s_ok, p_ok, fnd);
      csr_access(12'h7C0, 1'b0, 3'b001, 32'h0000_0041, r, v);
    join
    checks++; if (fnd !== 1'b1 || b !== 8'h41 || p_ok !== 1'b1) begin errors++; $display("FAIL tx_byte_41 got %h found %b stop %b expected 41 1 1", b, fnd, p_ok); end
    repeat (DIV) @(negedge clk);
  endtask

  task automatic test_rx_byte();
    logic [31:0] r;
    logic        v;
    send_rx(8'hA3, 1'b1);
    model_full = 1'b1; model_byte = 8'hA3;
    repeat (4) @(negedge clk);
    csr_access(12'h7C0, 1'b0, 3'b000, 32'h0, r, v);
    checks++; if (r !== 32'h0000_00A3) begin errors++; $display("FAIL rx_peek_a3 got %h expected 000000a3", r); end
    csr_access(12'h7C0, 1'b1, 3'b000, 32'h0, r, v);
    checks++; if (r !== 32'h0000_00A3) begin errors++; $display("FAIL rx_read_a3 got %h expected 000000a3", r); end
    model_full = 1'b0;
    csr_access(12'h7C0, 1'b1, 3'b000, 32'h0, r, v);
    checks++; if (r !== 32'h8000_0000) begin errors++; $display("FAIL rx_consumed got %h expected 80000000", r); end
  endtask

  task automatic test_rx_errors();
    logic [31:0] r;
    logic        v;
    send_rx(8'hC3, 1'b0);
    repeat (DIV) @(negedge clk);
    csr_access(12'h7C0, 1'b0, 3'b000, 32'h0, r, v);
    checks++; if (r !== 32'h8000_0000) begin errors++; $display("FAIL rx_framing_error got %h expected 80000000", r); end
    rx = 1'b0;
    repeat (100) @(negedge clk);
    rx = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    csr_access(12'h7C0, 1'b0, 3'b000, 32'h0, r, v);
    checks++; if (r !== 32'h8000_0000) begin errors++; $display("FAIL rx_glitch_reject got %h expected 80000000", r); end
  endtask

  task automatic test_random_duplex();
    logic [7:0]  tb_byte, rb_byte, b;
    logic        good, consume, s_ok, p_ok, fnd, v, vw;
    int          low_run;
    logic [31:0] r, rw;
    for (int it = 0; it < 6; it++) begin
      tb_byte = 8'($urandom);
      rb_byte = 8'($urandom);
      good    = (it < 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
      consume = (it == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      fork
        capture_tx(b, low_run, s_ok, p_ok, fnd);
        csr_access(12'h7C0, 1'b0, 3'b001, {24'h0, tb_byte}, rw, vw);
        send_rx(rb_byte, good);
      join
      if (good) begin
        model_full = 1'b1;
        model_byte = rb_byte;
      end
      repeat (DIV) @(negedge clk);
      checks++; if (fnd !== 1'b1 || b !== tb_byte || p_ok !== 1'b1) begin errors++; $display("FAIL duplex_tx it %0d got %h stop %b expected %h 1", it, b, p_ok, tb_byte); end
      csr_access(12'h7C0, consume, 3'b000, 32'h0, r, v);
      checks++; if (r !== exp_status(1'b0)) begin errors++; $display("FAIL duplex_rx it %0d got %h expected %h", it, r, exp_status(1'b0)); end
      if (consume) model_full = 1'b0;
    end
  endtask

  task automatic test_reset_mid_tx();
    logic [7:0]  b;
    int          low_run;
    logic        s_ok, p_ok, fnd, v;
    logic [31:0] r;
    csr_access(12'h7C0, 1'b0, 3'b001, 32'h0000_003C, r, v);
    repeat (1000) @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_mid_tx_line got %b expected 1", tx); end
    @(negedge clk);
    rstn = 1'b1;
    model_full = 1'b0;
    @(negedge clk);
    csr_access(12'h7C0, 1'b0, 3'b000, 32'h0, r, v);
    checks++; if (r !== exp_status(1'b0)) begin errors++; $display("FAIL reset_mid_tx_status got %h expected %h", r, exp_status(1'b0)); end
    fork
      capture_tx(b, low_run, s_ok, p_ok, fnd);
      csr_access(12'h7C0, 1'b0, 3'b001, 32'h0000_0096, r, v);
    join
    checks++; if (fnd !== 1'b1 || b !== 8'h96 || p_ok !== 1'b1 || s_ok !== 1'b1) begin errors++; $display("FAIL post_reset_frame got %h found %b stop %b expected 96 1 1", b, fnd, p_ok); end
  endtask

  initial begin
    test_reset();
    test_tx_frame();
    test_tx_after_drop();
    test_rx_byte();
    test_rx_errors();
    test_random_duplex();
    test_reset_mid_tx();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
